// File: rtl/uart_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_ctrl_if
// Bridge-side bundle of the UART controller: the active-low write/read
// strobes, the read target select, the transmit byte, and the ready flags
// plus receive byte returned to the bridge.
//   master : bridge side (drives strobes and tx data)
//   slave  : uart_ctrl side (drives ready flags and rx data)
// -----------------------------------------------------------------------------
interface uart_ctrl_if;
    logic       uart_we_n_i;
    logic       uart_re_n_i;
    logic       uart_rd_data_sel_i;
    logic [7:0] uart_tx_data_i;
    logic       uart_tx_ready_o;
    logic       uart_rx_ready_o;
    logic [7:0] uart_rx_data_o;

    modport master (
        output uart_we_n_i,
        output uart_re_n_i,
        output uart_rd_data_sel_i,
        output uart_tx_data_i,
        input  uart_tx_ready_o,
        input  uart_rx_ready_o,
        input  uart_rx_data_o
    );

    modport slave (
        input  uart_we_n_i,
        input  uart_re_n_i,
        input  uart_rd_data_sel_i,
        input  uart_tx_data_i,
        output uart_tx_ready_o,
        output uart_rx_ready_o,
        output uart_rx_data_o
    );
endinterface

// File: rtl/uart_ctrl.sv
// -----------------------------------------------------------------------------
// uart_ctrl
// Serial end of the UART path. Turns bridge write strobes into 8N1 frames on
// txd and deserialises rxd into a receive buffer whose state is reported to
// the bridge through the ready flags.
//
// Ports:
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_ctrl_if.slave (we_n/re_n strobes, read select, tx byte,
//            tx/rx ready flags, rx byte)
//   txd    : serial output, idles high
//   rxd    : serial input, asynchronous to clk
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), RX_FIFO_DEPTH (power of two).
// Bit time DIV = CLK_FREQ/BAUD clock cycles, must be at least 4.
//
// Build option: define UART_RX_FIFO_EN to replace the single-byte receive
// buffer with an RX_FIFO_DEPTH-entry FIFO.
// -----------------------------------------------------------------------------
module uart_ctrl #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 9600,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_ctrl_if.slave bus,
    output logic       txd,
    input  logic       rxd
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV < 4) ? 2 : $clog2(DIV);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    // A zero or negative FIFO depth is never meaningful, even when unused.
    generate
        if (DIV < 4 || RX_FIFO_DEPTH < 1) begin : g_bad_cfg
            $error("uart_ctrl: CLK_FREQ/BAUD must be >= 4 and RX_FIFO_DEPTH >= 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Transmitter
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             txd_q;
    logic             tx_ready_q;
    logic             tx_tick;

    assign tx_tick = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!bus.uart_we_n_i && tx_ready_q) begin
                        tx_shift_q <= bus.uart_tx_data_i;
                        tx_cnt_q   <= '0;
                        txd_q      <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
                    if (tx_tick) begin
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
                    if (tx_tick) begin
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
                    // Ready rises right after the stop bit's last cycle, so a
                    // write on that cycle starts the next frame back to back.
                    if (tx_tick) begin
                        tx_ready_q <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign txd                 = txd_q;
    assign bus.uart_tx_ready_o = tx_ready_q;

    // -------------------------------------------------------------------------
    // Receiver front end: two-flop synchronizer plus one delayed copy for
    // falling-edge detection. All idle-high so reset never fakes a start bit.
    // -------------------------------------------------------------------------
    logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver FSM
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_push_q;
    logic [7:0]       rx_byte_q;
    logic             rx_tick;
    logic             rx_half_tick;

    assign rx_tick      = (rx_cnt_q == BIT_LAST);
    assign rx_half_tick = (rx_cnt_q == HALF_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_push_q  <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_push_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rxd_prev_q && !rxd_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // Half a bit in: line must still be low, else it was a glitch.
                    rx_cnt_q <= rx_half_tick ? '0 : rx_cnt_q + CNT_W'(1);
                    if (rx_half_tick) begin
                        rx_bit_q   <= '0;
                        rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + CNT_W'(1);
                    if (rx_tick) begin
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + CNT_W'(1);
                    if (rx_tick) begin
                        if (rxd_s2_q) begin
                            rx_push_q  <= 1'b1;
                            rx_byte_q  <= rx_shift_q;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_WAIT;
                        end
                    end
                end
                RX_WAIT: begin
                    // Framing error: stay out of IDLE until the line is released,
                    // otherwise a held-low line would look like a new start bit.
                    if (rxd_s2_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read strobe: pop only on the falling edge of re_n for a data read.
    // -------------------------------------------------------------------------
    logic re_n_prev_q;
    logic rx_ready_q;
    logic rx_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_n_prev_q <= 1'b1;
        end else begin
            re_n_prev_q <= bus.uart_re_n_i;
        end
    end

    assign rx_pop = !bus.uart_re_n_i && re_n_prev_q && bus.uart_rd_data_sel_i && rx_ready_q;

    // -------------------------------------------------------------------------
    // Receive buffer
    // -------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
    localparam int AW = (RX_FIFO_DEPTH < 2) ? 1 : $clog2(RX_FIFO_DEPTH);

    generate
        if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_ctrl: RX_FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]  fifo_mem_q [RX_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        rx_ready_d;
    logic        fifo_full;
    logic        fifo_wr;

    assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // When full, a pop frees the head slot in the same edge, which is exactly
    // the slot the write pointer addresses, so push+pop when full is safe.
    assign fifo_wr   = rx_push_q && (!fifo_full || rx_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rx_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        rx_ready_d = (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= rx_byte_q;
        end
    end

    assign bus.uart_rx_data_o = rx_ready_q ? fifo_mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
`else
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_ready_d;

    // A push into a full buffer is dropped unless the same edge pops it.
    always_comb begin
        rx_ready_d = rx_ready_q;
        rx_data_d  = rx_data_q;
        if (rx_pop) begin
            rx_ready_d = 1'b0;
        end
        if (rx_push_q && (!rx_ready_q || rx_pop)) begin
            rx_ready_d = 1'b1;
            rx_data_d  = rx_byte_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_data_q <= rx_data_d;
    end

    assign bus.uart_rx_data_o = rx_ready_q ? rx_data_q : 8'h00;
`endif

    assign bus.uart_rx_ready_o = rx_ready_q;

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Serial end of the UART path. Turns the bridge's UART strobes (uart_we_n_o / uart_re_n_o / uart_tx_data_o) into 8N1 serial frames on txd.
- Deserialises rxd into a receive buffer and reports the status bits the bridge returns at 0xbfd003fc (bit0 tx idle, bit1 rx data).
- Sits between the bridge and the board UART pins; single clock domain; rxd is asynchronous.

Parameters:
- CLK_FREQ, 50000000, core clock in Hz.
- BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer divide); DIV < 4 is illegal (elaboration error).
- RX_FIFO_DEPTH, 16, receive FIFO entries, power of two; used only with UART_RX_FIFO_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- uart_we_n_i  in  1  write strobe from bridge, active-low.
- uart_re_n_i  in  1  read strobe from bridge, active-low.
- uart_rd_data_sel_i  in  1  1 = read targets data register (addr 0x..f8), 0 = status (0x..fc); driven from lsu_addr[2] inverted.
- uart_tx_data_i  in  8  byte to transmit.
- uart_tx_ready_o  out  1  1 = transmitter idle, write accepted.
- uart_rx_ready_o  out  1  1 = received byte available.
- uart_rx_data_o  out  8  oldest received byte (combinational from buffer head).
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous.

Behaviour:
- Reset (asynchronous, immediate): txd=1, uart_tx_ready_o=1, uart_rx_ready_o=0, uart_rx_data_o=0. A frame in flight is aborted on either side; FSMs go to IDLE.
- TX accept:
  - Sampled at a rising edge with uart_we_n_i=0 and uart_tx_ready_o=1: latch uart_tx_data_i; uart_tx_ready_o=0 from the next cycle.
  - Write while busy is silently dropped. A strobe held low for several cycles sends exactly one byte, because ready is already low.
- TX FSM IDLE->START->DATA->STOP->IDLE:
  - txd goes low the cycle after accept.
  - Each bit lasts exactly DIV cycles. Data is sent LSB first, then a stop bit (1).
  - uart_tx_ready_o returns to 1 on the cycle after the stop bit's last cycle, so busy time = 10*DIV cycles.
  - A write on that first ready cycle starts the next frame with no gap.
- RX front end: 2-flop synchronizer on rxd, reset value 1. Start detection on synced 1->0.
- RX FSM IDLE->START->DATA->STOP->IDLE:
  - START: wait DIV/2 cycles. If rxd is synced high, treat as a glitch and return to IDLE.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample after DIV cycles.
    - Stop = 1: byte is valid and pushed.
    - Stop = 0 (framing error): byte is discarded; FSM waits for synced rxd=1 before returning to IDLE.
- RX pop:
  - Occurs on a rising edge where uart_re_n_i=0, uart_re_n_i was 1 the previous cycle, uart_rd_data_sel_i=1 and uart_rx_ready_o=1.
  - Held strobes pop once. Status reads (sel=0) never pop.
- Buffer without FIFO: one byte plus valid flag.
  - Push while valid: new byte dropped, old byte kept (overrun).
  - Push and pop on the same edge: new byte stored, valid stays 1.
- uart_rx_ready_o and uart_tx_ready_o are registered outputs.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: receive path uses an RX_FIFO_DEPTH-entry FIFO.
  - uart_rx_ready_o = not empty; uart_rx_data_o = head.
  - Push when full drops the incoming byte. Simultaneous push+pop when full is accepted.
  - Pointers wrap modulo depth.
- Undefined: single-entry buffer as described in Behaviour; RX_FIFO_DEPTH ignored.

Test Plan (bench uses CLK_FREQ=16, BAUD=1, DIV=16):
- Reset, then we_n low 1 cycle with data 0xA5 -> tx_ready 0 next cycle. txd = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16; tx_ready=1 exactly 160 cycles after the low-going cycle.
- Write 0x3C while busy sending 0x55 -> only 0x55 appears on txd; 0x3C lost; tx_ready stays 0 until frame end.
- Drive rxd frame 0x5A with 8N1 at DIV=16 -> rx_ready=1 after stop sample; rx_data=0x5A. Status read (sel=0) for 3 cycles leaves rx_ready=1. Data read held 3 cycles pops once: rx_ready=0.
- rxd low pulse of 4 cycles -> no byte, rx_ready stays 0. Frame 0x81 with stop bit 0 -> discarded, rx_ready 0.
- Two frames 0x11, 0x22 with no read -> non-FIFO: rx_data=0x11 after both, 0x22 lost. UART_RX_FIFO_EN: reads return 0x11 then 0x22; 17 frames -> 17th dropped.
- Assert rst_n low mid-TX frame (bit 3) -> txd=1 and tx_ready=1 immediately; after release, new write 0xFF transmits a complete frame.
